// File: rtl/apb_port_router.sv
// apb_port_router
//   Routes one upstream APB transfer to one of NUM_PORTS downstream APB
//   requester ports, chosen by the explicit index s_port. Downstream wait
//   states are honoured, and PRDATA/PSLVERR are returned upstream. An index
//   >= NUM_PORTS completes immediately with an error and produces no
//   downstream activity. Every output is driven straight from a flop.
//
//   Optional feature macro: APB_ROUTER_TIMEOUT_EN
//     When it is defined, an ACCESS phase that stays unanswered for
//     TIMEOUT_CYCLES cycles is aborted and answered with an error.
//     When it is undefined, ACCESS waits indefinitely.
//
//   Ports
//     clk, rst        clock; asynchronous active-low reset
//     s_psel/s_penable/s_pwrite/s_port/s_paddr/s_pwdata
//                     upstream request; sampled only in IDLE
//     s_prdata/s_pready/s_pslverr
//                     upstream response; s_pready is a one-cycle pulse
//     m_psel          one-hot downstream select
//     m_penable/m_pwrite/m_paddr/m_pwdata
//                     shared downstream buses; they hold after a transfer
//     m_prdata/m_pready/m_pslverr
//                     downstream returns; port i uses slice [i*DATA_W +: DATA_W]
module apb_port_router #(
  parameter int NUM_PORTS      = 6,
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int SEL_W          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_psel,
  input  logic                        s_penable,
  input  logic                        s_pwrite,
  input  logic [SEL_W-1:0]            s_port,
  input  logic [ADDR_W-1:0]           s_paddr,
  input  logic [DATA_W-1:0]           s_pwdata,
  output logic [DATA_W-1:0]           s_prdata,
  output logic                        s_pready,
  output logic                        s_pslverr,
  output logic [NUM_PORTS-1:0]        m_psel,
  output logic                        m_penable,
  output logic                        m_pwrite,
  output logic [ADDR_W-1:0]           m_paddr,
  output logic [DATA_W-1:0]           m_pwdata,
  input  logic [NUM_PORTS*DATA_W-1:0] m_prdata,
  input  logic [NUM_PORTS-1:0]        m_pready,
  input  logic [NUM_PORTS-1:0]        m_pslverr
);

  if (NUM_PORTS < 2 || NUM_PORTS > 16 || (1 << SEL_W) < NUM_PORTS ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_port_router: invalid parameter set");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q;
  logic [SEL_W-1:0]      port_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_W-1:0]     rdata_q;

  logic [NUM_PORTS-1:0]  m_psel_q;
  logic                  m_penable_q;
  logic                  m_pwrite_q;
  logic [ADDR_W-1:0]     m_paddr_q;
  logic [DATA_W-1:0]     m_pwdata_q;
  logic [DATA_W-1:0]     s_prdata_q;
  logic                  s_pready_q;
  logic                  s_pslverr_q;

`ifdef APB_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]      tmo_cnt_q;
`endif

  logic [NUM_PORTS-1:0]  req_onehot;
  logic                  req_legal;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_W-1:0]     sel_rdata;

  // Decoding by comparison in a loop keeps the index width independent of
  // NUM_PORTS, and it yields an all-zero one-hot for out-of-range indices.
  always_comb begin
    req_onehot = '0;
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (s_port == SEL_W'(i)) begin
        req_onehot[i] = 1'b1;
      end
      if (port_q == SEL_W'(i)) begin
        sel_ready = m_pready[i];
        sel_err   = m_pslverr[i];
        sel_rdata = m_prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_legal = int'(s_port) < NUM_PORTS;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      port_q      <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      m_psel_q    <= '0;
      m_penable_q <= 1'b0;
      m_pwrite_q  <= 1'b0;
      m_paddr_q   <= '0;
      m_pwdata_q  <= '0;
      s_prdata_q  <= '0;
      s_pready_q  <= 1'b0;
      s_pslverr_q <= 1'b0;
`ifdef APB_ROUTER_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          s_pready_q  <= 1'b0;
          s_pslverr_q <= 1'b0;
          s_prdata_q  <= '0;
          if (s_psel && !s_penable) begin
            port_q  <= s_port;
            write_q <= s_pwrite;
            if (req_legal) begin
              // The shared buses are loaded only for a legal index, so an
              // illegal request leaves the downstream side untouched.
              m_psel_q   <= req_onehot;
              m_pwrite_q <= s_pwrite;
              m_paddr_q  <= s_paddr;
              m_pwdata_q <= s_pwdata;
              state_q    <= SETUP;
            end else begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= RESP;
            end
          end
        end

        SETUP: begin
          m_penable_q <= 1'b1;
`ifdef APB_ROUTER_TIMEOUT_EN
          tmo_cnt_q   <= '0;
`endif
          state_q     <= ACCESS;
        end

        ACCESS: begin
          if (sel_ready) begin
            err_q       <= sel_err;
            rdata_q     <= sel_rdata;
            m_psel_q    <= '0;
            m_penable_q <= 1'b0;
            state_q     <= RESP;
          end
`ifdef APB_ROUTER_TIMEOUT_EN
          else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_q       <= 1'b1;
            rdata_q     <= '0;
            m_psel_q    <= '0;
            m_penable_q <= 1'b0;
            state_q     <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
`endif
        end

        RESP: begin
          // The response flops load on the way out of RESP, so the upstream
          // pulse appears in the cycle after RESP, which is already IDLE.
          s_pready_q  <= 1'b1;
          s_pslverr_q <= err_q;
          s_prdata_q  <= write_q ? '0 : rdata_q;
          state_q     <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_psel    = m_psel_q;
  assign m_penable = m_penable_q;
  assign m_pwrite  = m_pwrite_q;
  assign m_paddr   = m_paddr_q;
  assign m_pwdata  = m_pwdata_q;
  assign s_prdata  = s_prdata_q;
  assign s_pready  = s_pready_q;
  assign s_pslverr = s_pslverr_q;

endmodule

// File: tb/tb_apb_port_router.sv
module tb_apb_port_router;

  localparam int NP = 6;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic              clk;
  logic              rst;
  logic              s_psel;
  logic              s_penable;
  logic              s_pwrite;
  logic [SW-1:0]     s_port;
  logic [AW-1:0]     s_paddr;
  logic [DW-1:0]     s_pwdata;
  logic [DW-1:0]     s_prdata;
  logic              s_pready;
  logic              s_pslverr;
  logic [NP-1:0]     m_psel;
  logic              m_penable;
  logic              m_pwrite;
  logic [AW-1:0]     m_paddr;
  logic [DW-1:0]     m_pwdata;
  logic [NP*DW-1:0]  m_prdata;
  logic [NP-1:0]     m_pready;
  logic [NP-1:0]     m_pslverr;

  int n_cmp = 0;
  int n_err = 0;

  apb_port_router #(
    .NUM_PORTS(NP),
    .ADDR_W(AW),
    .DATA_W(DW),
    .SEL_W(SW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_psel(s_psel),
    .s_penable(s_penable),
    .s_pwrite(s_pwrite),
    .s_port(s_port),
    .s_paddr(s_paddr),
    .s_pwdata(s_pwdata),
    .s_prdata(s_prdata),
    .s_pready(s_pready),
    .s_pslverr(s_pslverr),
    .m_psel(m_psel),
    .m_penable(m_penable),
    .m_pwrite(m_pwrite),
    .m_paddr(m_paddr),
    .m_pwdata(m_pwdata),
    .m_prdata(m_prdata),
    .m_pready(m_pready),
    .m_pslverr(m_pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic rdy, input logic err,
                          input logic [DW-1:0] data);
    chk({tag, ".pready"},  64'(s_pready),  64'(rdy));
    chk({tag, ".pslverr"}, 64'(s_pslverr), 64'(err));
    chk({tag, ".prdata"},  64'(s_prdata),  64'(data));
  endtask

  // Present the APB setup phase upstream.
  task automatic req(input logic wr, input logic [SW-1:0] port,
                     input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    s_psel    = 1'b1;
    s_penable = 1'b0;
    s_pwrite  = wr;
    s_port    = port;
    s_paddr   = addr;
    s_pwdata  = wdata;
  endtask

  task automatic idle_bus();
    s_psel    = 1'b0;
    s_penable = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    s_psel    = 1'b0;
    s_penable = 1'b0;
    s_pwrite  = 1'b0;
    s_port    = '0;
    s_paddr   = '0;
    s_pwdata  = '0;
    m_prdata  = '0;
    m_pready  = '0;
    m_pslverr = '0;
    #2;
    chk("rst.m_psel", 64'(m_psel), 64'(0));
    chk("rst.m_penable", 64'(m_penable), 64'(0));
    chk("rst.m_pwrite", 64'(m_pwrite), 64'(0));
    chk("rst.m_paddr", 64'(m_paddr), 64'(0));
    chk("rst.m_pwdata", 64'(m_pwdata), 64'(0));
    chk_resp("rst", 1'b0, 1'b0, '0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Write to port 2, zero-wait slave
    m_pready = 6'b000100;
    req(1'b1, 4'd2, 12'h1A4, 32'hDEADBEEF);
    tick();                                   // capture edge
    chk("wr.setup.m_psel", 64'(m_psel), 64'(6'b000100));
    chk("wr.setup.m_penable", 64'(m_penable), 64'(0));
    chk("wr.setup.m_paddr", 64'(m_paddr), 64'(12'h1A4));
    chk("wr.setup.m_pwdata", 64'(m_pwdata), 64'(32'hDEADBEEF));
    chk("wr.setup.m_pwrite", 64'(m_pwrite), 64'(1));
    s_penable = 1'b1;
    tick();
    chk("wr.access.m_psel", 64'(m_psel), 64'(6'b000100));
    chk("wr.access.m_penable", 64'(m_penable), 64'(1));
    chk("wr.access.pready", 64'(s_pready), 64'(0));
    tick();
    chk("wr.done.m_psel", 64'(m_psel), 64'(0));
    chk("wr.done.m_penable", 64'(m_penable), 64'(0));
    chk("wr.c2.pready", 64'(s_pready), 64'(0));
    tick();                                   // 3 cycles after capture
    chk_resp("wr.resp", 1'b1, 1'b0, '0);
    idle_bus();
    tick();
    chk("wr.after.pready", 64'(s_pready), 64'(0));
    chk("wr.hold.m_paddr", 64'(m_paddr), 64'(12'h1A4));
    chk("wr.hold.m_pwdata", 64'(m_pwdata), 64'(32'hDEADBEEF));

    // Read from port 5 with 4 wait states; other ports' ready/data ignored
    m_prdata[5*DW +: DW] = 32'h12345678;
    m_prdata[2*DW +: DW] = 32'hAAAA5555;
    m_pready = 6'b011111;
    req(1'b0, 4'd5, 12'h0F0, 32'h0);
    tick();
    chk("rd5.setup.m_psel", 64'(m_psel), 64'(6'b100000));
    chk("rd5.setup.m_pwrite", 64'(m_pwrite), 64'(0));
    chk("rd5.setup.m_paddr", 64'(m_paddr), 64'(12'h0F0));
    s_penable = 1'b1;
    s_port    = 4'd1;                         // ignored after capture
    tick();
    chk("rd5.access.m_penable", 64'(m_penable), 64'(1));
    for (int w = 0; w < 4; w++) begin
      tick();
      chk("rd5.wait.m_psel", 64'(m_psel), 64'(6'b100000));
      chk("rd5.wait.pready", 64'(s_pready), 64'(0));
    end
    m_pready = 6'b111111;
    tick();
    chk("rd5.done.m_psel", 64'(m_psel), 64'(0));
    chk("rd5.c6.pready", 64'(s_pready), 64'(0));
    tick();                                   // 7 cycles after capture
    chk_resp("rd5.resp", 1'b1, 1'b0, 32'h12345678);
    idle_bus();
    tick();
    chk("rd5.after.pready", 64'(s_pready), 64'(0));

    // Illegal port index 7
    req(1'b0, 4'd7, 12'h3FF, 32'h0);
    tick();
    chk("bad.m_psel", 64'(m_psel), 64'(0));
    chk("bad.c0.pready", 64'(s_pready), 64'(0));
    chk("bad.m_paddr", 64'(m_paddr), 64'(12'h0F0));
    s_penable = 1'b1;
    tick();
    chk_resp("bad.resp", 1'b1, 1'b1, '0);
    chk("bad.resp.m_psel", 64'(m_psel), 64'(0));
    idle_bus();
    tick();
    chk("bad.after.pready", 64'(s_pready), 64'(0));

    // Read port 0 with slave error, then port 1 without
    m_prdata[0*DW +: DW] = 32'hCAFEF00D;
    m_prdata[1*DW +: DW] = 32'h0BADC0DE;
    m_pready  = 6'b000001;
    m_pslverr = 6'b000001;
    req(1'b0, 4'd0, 12'h010, 32'h0);
    tick();
    s_penable = 1'b1;
    tick();
    tick();
    tick();
    chk_resp("rd0.resp", 1'b1, 1'b1, 32'hCAFEF00D);
    idle_bus();
    tick();
    m_pready  = 6'b000010;
    m_pslverr = 6'b111101;
    req(1'b0, 4'd1, 12'h020, 32'h0);
    tick();
    chk("rd1.setup.m_psel", 64'(m_psel), 64'(6'b000010));
    s_penable = 1'b1;
    tick();
    tick();
    tick();
    chk_resp("rd1.resp", 1'b1, 1'b0, 32'h0BADC0DE);
    idle_bus();
    tick();

    // Reset during ACCESS on port 3
    m_pready  = 6'b000000;
    m_pslverr = 6'b000000;
    req(1'b1, 4'd3, 12'h555, 32'h01234567);
    tick();
    s_penable = 1'b1;
    tick();
    chk("rst3.access.m_psel", 64'(m_psel), 64'(6'b001000));
    chk("rst3.access.m_penable", 64'(m_penable), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("rst3.m_psel", 64'(m_psel), 64'(0));
    chk("rst3.m_penable", 64'(m_penable), 64'(0));
    chk("rst3.m_pwrite", 64'(m_pwrite), 64'(0));
    chk("rst3.m_paddr", 64'(m_paddr), 64'(0));
    chk("rst3.m_pwdata", 64'(m_pwdata), 64'(0));
    chk_resp("rst3", 1'b0, 1'b0, '0);
    idle_bus();
    tick();
    rst = 1'b1;
    tick();
    chk("rst3.idle.pready", 64'(s_pready), 64'(0));
    m_pready = 6'b000010;
    req(1'b0, 4'd1, 12'h024, 32'h0);
    tick();
    chk("rd1b.setup.m_psel", 64'(m_psel), 64'(6'b000010));
    s_penable = 1'b1;
    tick();
    tick();
    tick();
    chk_resp("rd1b.resp", 1'b1, 1'b0, 32'h0BADC0DE);
    idle_bus();
    tick();

`ifdef APB_ROUTER_TIMEOUT_EN
    // Slave on port 4 never answers
    m_pready = 6'b000000;
    req(1'b0, 4'd4, 12'h044, 32'h0);
    tick();
    s_penable = 1'b1;
    tick();                                   // first ACCESS cycle begins
    for (int c = 0; c < TO - 1; c++) begin
      tick();
      chk("tmo.wait.m_psel", 64'(m_psel), 64'(6'b010000));
    end
    tick();                                   // 16 ACCESS cycles elapsed
    chk("tmo.abort.m_psel", 64'(m_psel), 64'(0));
    chk("tmo.abort.m_penable", 64'(m_penable), 64'(0));
    m_pready = 6'b010000;                     // late ready must be ignored
    tick();
    chk_resp("tmo.resp", 1'b1, 1'b1, '0);
    idle_bus();
    tick();
    chk("tmo.after.pready", 64'(s_pready), 64'(0));
    chk("tmo.after.m_psel", 64'(m_psel), 64'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_port_router.md
Name: apb_port_router

Overview:
Parametrised successor to the team's fixed six-port APB slave router. It accepts one APB transaction on an upstream completer interface and forwards it to one of NUM_PORTS downstream APB requester ports, selected by an explicit port index. Unlike the earlier block, it honours downstream PREADY wait states, returns PRDATA/PSLVERR upstream, and flags illegal port indices as errors. It sits between the APB master and the peripheral slaves in the interconnect.

Parameters:
NUM_PORTS, 6, number of downstream ports (2..16)
ADDR_W, 12, address width
DATA_W, 32, data width
SEL_W, 4, port-index width; must satisfy 2**SEL_W >= NUM_PORTS
TIMEOUT_CYCLES, 16, ACCESS-phase timeout in cycles; used only when APB_ROUTER_TIMEOUT_EN is defined

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
s_psel  in  1  upstream select
s_penable  in  1  upstream enable
s_pwrite  in  1  1 = write, 0 = read
s_port  in  SEL_W  target port index
s_paddr  in  ADDR_W  upstream address
s_pwdata  in  DATA_W  upstream write data
s_prdata  out  DATA_W  read data returned upstream
s_pready  out  1  upstream ready, one-cycle pulse
s_pslverr  out  1  upstream error, valid only while s_pready=1
m_psel  out  NUM_PORTS  one-hot downstream select
m_penable  out  1  shared downstream enable
m_pwrite  out  1  shared downstream write
m_paddr  out  ADDR_W  shared downstream address
m_pwdata  out  DATA_W  shared downstream write data
m_prdata  in  NUM_PORTS*DATA_W  downstream read data; port i occupies [i*DATA_W +: DATA_W]
m_pready  in  NUM_PORTS  downstream ready
m_pslverr  in  NUM_PORTS  downstream error

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs are 0: m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, s_prdata, s_pready, s_pslverr. Internal request registers are cleared.
- All outputs are registered. There is no combinational path from input to output.
- IDLE:
  - If s_psel=1 and s_penable=0, latch s_port, s_paddr, s_pwdata and s_pwrite.
  - If s_port < NUM_PORTS, go to SETUP. Otherwise go to RESP with error=1 and data=0; no downstream activity occurs.
- SETUP (1 cycle): m_psel[port]=1, m_penable=0, and the shared address, write and data buses driven from the latched values. Go to ACCESS.
- ACCESS: m_psel[port]=1, m_penable=1.
  - Wait while m_pready[port]=0.
  - When m_pready[port]=1, capture m_prdata slice and m_pslverr[port], clear m_psel and m_penable, go to RESP.
  - Signals from non-selected ports are ignored.
- RESP (1 cycle): s_pready=1, s_pslverr=captured error, s_prdata=captured data. s_prdata is forced to 0 for writes. Next state is IDLE, and s_pready returns to 0.
- The shared m_paddr, m_pwdata and m_pwrite hold their values after a transfer; they are not zeroed.
- Latency: with a zero-wait slave, s_pready rises 3 cycles after the IDLE capture edge. Each downstream wait cycle adds 1. An illegal port index takes 1 cycle.
- Upstream changes (s_psel dropping, new s_port) after capture are ignored until the block returns to IDLE.
- Back-to-back transfers: a new request is accepted only in IDLE. The minimum spacing is therefore one idle cycle after s_pready.
- Reset asserted mid-transaction: immediate return to reset values. The pending transfer is dropped with no response.

Optional Feature:
APB_ROUTER_TIMEOUT_EN
- Defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle.
  - If TIMEOUT_CYCLES cycles elapse without m_pready[port], the block drops m_psel and m_penable and goes to RESP with s_pslverr=1 and s_prdata=0.
  - A late m_pready after the abort is ignored.
- Not defined: no counter; ACCESS waits indefinitely.

Test Plan:
- Write, port 2, addr 0x1A4, data 0xDEADBEEF, zero-wait slave -> m_psel=0b000100 in SETUP, m_penable=1 in the next cycle; s_pready pulses 3 cycles after capture with s_pslverr=0 and s_prdata=0.
- Read, port 5, slave inserts 4 wait states, m_prdata slice 5 = 0x12345678 -> s_pready 7 cycles after capture, s_prdata=0x12345678; other ports' m_psel stay 0 throughout.
- Port index 7 with NUM_PORTS=6 -> m_psel stays 0; s_pready and s_pslverr both 1 one cycle after capture; s_prdata=0.
- Read, port 0, m_pslverr[0]=1 together with m_pready[0]=1 -> s_pslverr=1 on the s_pready cycle; a following read to port 1 with m_pslverr[1]=0 returns s_pslverr=0.
- rst driven low during ACCESS on port 3 -> all outputs 0 asynchronously; after release, a read on port 1 completes normally.
- With APB_ROUTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never ready -> m_psel cleared after 16 ACCESS cycles; s_pready=1, s_pslverr=1, s_prdata=0; block then returns to IDLE.
